// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard and the forwarding comparator that consumes it.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } slot_t;

  // Forwarding mux select encodings, shared with the consumer side.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MODE_SHIFT,
    MODE_HOLD,
    MODE_FLUSH,
    MODE_STALL
  } mode_e;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter: advances by one when enabled and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destinations through ID/EX, EX/MEM, MEM/WB
// and issues load-use stall, bubble and flush controls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              valid_ID_i,
  input  logic [REG_AW-1:0] RS_addr_ID_i,
  input  logic [REG_AW-1:0] RT_addr_ID_i,
  input  logic              uses_rt_ID_i,
  input  logic [REG_AW-1:0] dest_ID_i,
  input  logic              RegWrite_ID_i,
  input  logic              MemRead_ID_i,
  input  logic              branch_taken_EX_i,
  output logic [REG_AW-1:0] RS_addr_IDEX_o,
  output logic [REG_AW-1:0] RT_addr_IDEX_o,
  output logic [REG_AW-1:0] Mux_RegDst_EXMEM_o,
  output logic [REG_AW-1:0] Mux_RegDst_MEMWB_o,
  output logic              EXMEM_WB1_o,
  output logic              MEMWB_WB1_o,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IFID_Flush_o,
  output logic              IDEX_Bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  slot_t             idex_q, idex_d;
  slot_t             exmem_q, exmem_d;
  slot_t             memwb_q, memwb_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  mode_e             mode;
  logic              lu;
  logic              stall_en;
  logic              flush_en;

  // Only a load one stage ahead is too close for forwarding; register 0 never hazards.
  assign lu = valid_ID_i & idex_q.valid & idex_q.memread & idex_q.regwrite &
              (idex_q.dest != ZERO_REG) &
              ((idex_q.dest == RS_addr_ID_i) |
               (uses_rt_ID_i & (idex_q.dest == RT_addr_ID_i)));

  // Hold freezes everything, and a taken branch wins over a stall.
  always_comb begin
    mode = MODE_SHIFT;
    if (!rst_i) begin
      mode = MODE_SHIFT;
    end else if (hold_i) begin
      mode = MODE_HOLD;
    end else if (branch_taken_EX_i) begin
      mode = MODE_FLUSH;
    end else if (lu) begin
      mode = MODE_STALL;
    end
  end

  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    case (mode)
      MODE_HOLD: begin
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end
      MODE_FLUSH: begin
        IFID_Flush_o  = 1'b1;
        IDEX_Bubble_o = 1'b1;
      end
      MODE_STALL: begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    case (mode)
      MODE_HOLD: begin
      end
      MODE_FLUSH, MODE_STALL: begin
        idex_d  = '0;
        rs_d    = '0;
        rt_d    = '0;
        exmem_d = idex_q;
        memwb_d = exmem_q;
      end
      default: begin
        idex_d  = '{valid: valid_ID_i, dest: dest_ID_i,
                    regwrite: RegWrite_ID_i, memread: MemRead_ID_i};
        rs_d    = RS_addr_ID_i;
        rt_d    = RT_addr_ID_i;
        exmem_d = idex_q;
        memwb_d = exmem_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

  assign RS_addr_IDEX_o     = rs_q;
  assign RT_addr_IDEX_o     = rt_q;
  assign Mux_RegDst_EXMEM_o = exmem_q.dest;
  assign Mux_RegDst_MEMWB_o = memwb_q.dest;
  assign EXMEM_WB1_o        = exmem_q.valid & exmem_q.regwrite;
  assign MEMWB_WB1_o        = memwb_q.valid & memwb_q.regwrite;

  assign stall_en = (mode == MODE_STALL);
  assign flush_en = (mode == MODE_FLUSH);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (stall_en),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (flush_en),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with 4-bit counters
// makes counter saturation reachable in a short run.
module tb_hazard_scoreboard;

  logic       clk_i;
  logic       rst_i;
  logic       hold_i;
  logic       valid_ID_i;
  logic [4:0] RS_addr_ID_i;
  logic [4:0] RT_addr_ID_i;
  logic       uses_rt_ID_i;
  logic [4:0] dest_ID_i;
  logic       RegWrite_ID_i;
  logic       MemRead_ID_i;
  logic       branch_taken_EX_i;

  logic [4:0]  RS_addr_IDEX_o, RT_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o;
  logic        EXMEM_WB1_o, MEMWB_WB1_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic [4:0] sRsIdex, sRtIdex, sDestExmem, sDestMemwb;
  logic       sWbExmem, sWbMemwb, sPcWrite, sIfidWrite, sIfidFlush, sBubble;
  logic [3:0] sStallCnt, sFlushCnt;

  int numCompared;
  int numMismatched;

  hazard_scoreboard #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .valid_ID_i(valid_ID_i),
    .RS_addr_ID_i(RS_addr_ID_i), .RT_addr_ID_i(RT_addr_ID_i), .uses_rt_ID_i(uses_rt_ID_i),
    .dest_ID_i(dest_ID_i), .RegWrite_ID_i(RegWrite_ID_i), .MemRead_ID_i(MemRead_ID_i),
    .branch_taken_EX_i(branch_taken_EX_i),
    .RS_addr_IDEX_o(RS_addr_IDEX_o), .RT_addr_IDEX_o(RT_addr_IDEX_o),
    .Mux_RegDst_EXMEM_o(Mux_RegDst_EXMEM_o), .Mux_RegDst_MEMWB_o(Mux_RegDst_MEMWB_o),
    .EXMEM_WB1_o(EXMEM_WB1_o), .MEMWB_WB1_o(MEMWB_WB1_o), .PCWrite_o(PCWrite_o),
    .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o), .IDEX_Bubble_o(IDEX_Bubble_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  hazard_scoreboard #(.CNT_W(4)) dutSmall (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .valid_ID_i(valid_ID_i),
    .RS_addr_ID_i(RS_addr_ID_i), .RT_addr_ID_i(RT_addr_ID_i), .uses_rt_ID_i(uses_rt_ID_i),
    .dest_ID_i(dest_ID_i), .RegWrite_ID_i(RegWrite_ID_i), .MemRead_ID_i(MemRead_ID_i),
    .branch_taken_EX_i(branch_taken_EX_i),
    .RS_addr_IDEX_o(sRsIdex), .RT_addr_IDEX_o(sRtIdex),
    .Mux_RegDst_EXMEM_o(sDestExmem), .Mux_RegDst_MEMWB_o(sDestMemwb),
    .EXMEM_WB1_o(sWbExmem), .MEMWB_WB1_o(sWbMemwb), .PCWrite_o(sPcWrite),
    .IFID_Write_o(sIfidWrite), .IFID_Flush_o(sIfidFlush), .IDEX_Bubble_o(sBubble),
    .stall_cnt_o(sStallCnt), .flush_cnt_o(sFlushCnt)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] d, input logic rw, input logic mr);
    valid_ID_i    = v;
    RS_addr_ID_i  = rs;
    RT_addr_ID_i  = rt;
    uses_rt_ID_i  = ut;
    dest_ID_i     = d;
    RegWrite_ID_i = rw;
    MemRead_ID_i  = mr;
  endtask

  task automatic doReset();
    tick();
    hold_i = 1'b0;
    branch_taken_EX_i = 1'b0;
    setId(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    hold_i = 1'b0;
    branch_taken_EX_i = 1'b0;
    setId(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    numCompared++; if (PCWrite_o !== 1'b1) begin numMismatched++; $display("[TB] FAIL reset_pcwrite: got %b expected 1", PCWrite_o); end
    numCompared++; if (IFID_Write_o !== 1'b1) begin numMismatched++; $display("[TB] FAIL reset_ifid_write: got %b expected 1", IFID_Write_o); end
    numCompared++; if ({IFID_Flush_o, IDEX_Bubble_o} !== 2'b00) begin numMismatched++; $display("[TB] FAIL reset_flush_bubble: got %b expected 00", {IFID_Flush_o, IDEX_Bubble_o}); end
    numCompared++; if ({EXMEM_WB1_o, MEMWB_WB1_o} !== 2'b00) begin numMismatched++; $display("[TB] FAIL reset_wb1: got %b expected 00", {EXMEM_WB1_o, MEMWB_WB1_o}); end
    numCompared++; if ({RS_addr_IDEX_o, RT_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o} !== 20'd0) begin numMismatched++; $display("[TB] FAIL reset_addrs: got %h expected 0", {RS_addr_IDEX_o, RT_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o}); end
    numCompared++; if ({stall_cnt_o, flush_cnt_o} !== 32'd0) begin numMismatched++; $display("[TB] FAIL reset_counters: got %h expected 0", {stall_cnt_o, flush_cnt_o}); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  task automatic test_load_use_rs();
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    numCompared++; if ({PCWrite_o, IFID_Write_o, IDEX_Bubble_o, IFID_Flush_o} !== 4'b0010) begin numMismatched++; $display("[TB] FAIL lu_rs_controls: got %b expected 0010", {PCWrite_o, IFID_Write_o, IDEX_Bubble_o, IFID_Flush_o}); end
    tick();
    numCompared++; if ({PCWrite_o, IFID_Write_o, IDEX_Bubble_o} !== 3'b110) begin numMismatched++; $display("[TB] FAIL lu_rs_one_cycle: got %b expected 110", {PCWrite_o, IFID_Write_o, IDEX_Bubble_o}); end
    numCompared++; if (stall_cnt_o !== 16'd1) begin numMismatched++; $display("[TB] FAIL lu_rs_stall_cnt: got %0d expected 1", stall_cnt_o); end
    numCompared++; if ({Mux_RegDst_EXMEM_o, EXMEM_WB1_o} !== {5'd2, 1'b1}) begin numMismatched++; $display("[TB] FAIL lu_rs_exmem: got dest %0d wb %b expected dest 2 wb 1", Mux_RegDst_EXMEM_o, EXMEM_WB1_o); end
    tick();
    numCompared++; if ({Mux_RegDst_MEMWB_o, MEMWB_WB1_o} !== {5'd2, 1'b1}) begin numMismatched++; $display("[TB] FAIL lu_rs_memwb: got dest %0d wb %b expected dest 2 wb 1", Mux_RegDst_MEMWB_o, MEMWB_WB1_o); end
    numCompared++; if (EXMEM_WB1_o !== 1'b0) begin numMismatched++; $display("[TB] FAIL lu_rs_exmem_bubble: got %b expected 0", EXMEM_WB1_o); end
    numCompared++; if ({RS_addr_IDEX_o, RT_addr_IDEX_o} !== {5'd2, 5'd4}) begin numMismatched++; $display("[TB] FAIL lu_rs_idex_regs: got rs %0d rt %0d expected rs 2 rt 4", RS_addr_IDEX_o, RT_addr_IDEX_o); end
    numCompared++; if (stall_cnt_o !== 16'd1) begin numMismatched++; $display("[TB] FAIL lu_rs_stall_cnt_after: got %0d expected 1", stall_cnt_o); end
  endtask

  task automatic test_load_use_rt();
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    numCompared++; if ({PCWrite_o, IDEX_Bubble_o} !== 2'b01) begin numMismatched++; $display("[TB] FAIL lu_rt_stall: got %b expected 01", {PCWrite_o, IDEX_Bubble_o}); end
    tick();
    numCompared++; if (stall_cnt_o !== 16'd1) begin numMismatched++; $display("[TB] FAIL lu_rt_stall_cnt: got %0d expected 1", stall_cnt_o); end
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd7, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    numCompared++; if ({PCWrite_o, IDEX_Bubble_o} !== 2'b10) begin numMismatched++; $display("[TB] FAIL lu_rt_unused_nostall: got %b expected 10", {PCWrite_o, IDEX_Bubble_o}); end
    tick();
    numCompared++; if (stall_cnt_o !== 16'd0) begin numMismatched++; $display("[TB] FAIL lu_rt_unused_cnt: got %0d expected 0", stall_cnt_o); end
    numCompared++; if ({RS_addr_IDEX_o, Mux_RegDst_EXMEM_o} !== {5'd7, 5'd5}) begin numMismatched++; $display("[TB] FAIL lu_rt_unused_shift: got rs %0d exmem %0d expected rs 7 exmem 5", RS_addr_IDEX_o, Mux_RegDst_EXMEM_o); end
  endtask

  task automatic test_zero_reg();
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    numCompared++; if ({PCWrite_o, IDEX_Bubble_o} !== 2'b10) begin numMismatched++; $display("[TB] FAIL zero_nostall: got %b expected 10", {PCWrite_o, IDEX_Bubble_o}); end
    tick();
    numCompared++; if (stall_cnt_o !== 16'd0) begin numMismatched++; $display("[TB] FAIL zero_stall_cnt: got %0d expected 0", stall_cnt_o); end
    numCompared++; if ({Mux_RegDst_EXMEM_o, EXMEM_WB1_o} !== {5'd0, 1'b1}) begin numMismatched++; $display("[TB] FAIL zero_exmem_wb1: got dest %0d wb %b expected dest 0 wb 1", Mux_RegDst_EXMEM_o, EXMEM_WB1_o); end
  endtask

  task automatic test_flush_beats_stall();
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    branch_taken_EX_i = 1'b1;
    #1;
    numCompared++; if ({IFID_Flush_o, IDEX_Bubble_o, PCWrite_o, IFID_Write_o} !== 4'b1111) begin numMismatched++; $display("[TB] FAIL flush_controls: got %b expected 1111", {IFID_Flush_o, IDEX_Bubble_o, PCWrite_o, IFID_Write_o}); end
    tick();
    branch_taken_EX_i = 1'b0;
    setId(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    numCompared++; if ({flush_cnt_o, stall_cnt_o} !== {16'd1, 16'd0}) begin numMismatched++; $display("[TB] FAIL flush_counters: got flush %0d stall %0d expected flush 1 stall 0", flush_cnt_o, stall_cnt_o); end
    numCompared++; if ({Mux_RegDst_EXMEM_o, EXMEM_WB1_o} !== {5'd2, 1'b1}) begin numMismatched++; $display("[TB] FAIL flush_exmem: got dest %0d wb %b expected dest 2 wb 1", Mux_RegDst_EXMEM_o, EXMEM_WB1_o); end
    numCompared++; if ({IFID_Flush_o, PCWrite_o} !== 2'b01) begin numMismatched++; $display("[TB] FAIL flush_released: got %b expected 01", {IFID_Flush_o, PCWrite_o}); end
  endtask

  task automatic test_hold();
    doReset();
    setId(1'b1, 5'd11, 5'd21, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd12, 5'd22, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd13, 5'd23, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd14, 5'd24, 1'b1, 5'd10, 1'b1, 1'b0);
    hold_i = 1'b1;
    branch_taken_EX_i = 1'b1;
    #1;
    numCompared++; if ({PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o} !== 4'b0000) begin numMismatched++; $display("[TB] FAIL hold_controls: got %b expected 0000", {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      numCompared++; if ({RS_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o, EXMEM_WB1_o, MEMWB_WB1_o} !== {5'd13, 5'd8, 5'd7, 2'b11}) begin numMismatched++; $display("[TB] FAIL hold_frozen_%0d: got rs %0d exmem %0d memwb %0d wb %b%b expected rs 13 exmem 8 memwb 7 wb 11", i, RS_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o, EXMEM_WB1_o, MEMWB_WB1_o); end
      numCompared++; if ({flush_cnt_o, stall_cnt_o, PCWrite_o} !== {32'd0, 1'b0}) begin numMismatched++; $display("[TB] FAIL hold_counters_%0d: got flush %0d stall %0d pcwrite %b expected 0 0 0", i, flush_cnt_o, stall_cnt_o, PCWrite_o); end
    end
    hold_i = 1'b0;
    branch_taken_EX_i = 1'b0;
    tick();
    numCompared++; if ({RS_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o} !== {5'd14, 5'd9, 5'd8}) begin numMismatched++; $display("[TB] FAIL hold_release: got rs %0d exmem %0d memwb %0d expected rs 14 exmem 9 memwb 8", RS_addr_IDEX_o, Mux_RegDst_EXMEM_o, Mux_RegDst_MEMWB_o); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    numCompared++; if ({PCWrite_o, stall_cnt_o} !== {1'b0, 16'd1}) begin numMismatched++; $display("[TB] FAIL midstall_setup: got pcwrite %b stall %0d expected 0 1", PCWrite_o, stall_cnt_o); end
    #2;
    rst_i = 1'b0;
    #1;
    numCompared++; if ({PCWrite_o, IFID_Write_o, IDEX_Bubble_o} !== 3'b110) begin numMismatched++; $display("[TB] FAIL midstall_controls: got %b expected 110", {PCWrite_o, IFID_Write_o, IDEX_Bubble_o}); end
    numCompared++; if ({EXMEM_WB1_o, MEMWB_WB1_o, Mux_RegDst_EXMEM_o} !== 7'd0) begin numMismatched++; $display("[TB] FAIL midstall_slots: got wb %b%b exmem %0d expected 0", EXMEM_WB1_o, MEMWB_WB1_o, Mux_RegDst_EXMEM_o); end
    numCompared++; if ({stall_cnt_o, flush_cnt_o} !== 32'd0) begin numMismatched++; $display("[TB] FAIL midstall_counters: got stall %0d flush %0d expected 0", stall_cnt_o, flush_cnt_o); end
    rst_i = 1'b1;
    tick();
    numCompared++; if ({PCWrite_o, stall_cnt_o} !== {1'b1, 16'd0}) begin numMismatched++; $display("[TB] FAIL midstall_no_residual: got pcwrite %b stall %0d expected 1 0", PCWrite_o, stall_cnt_o); end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 15; i++) begin
      setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
      tick();
      setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
      tick();
    end
    numCompared++; if ({sStallCnt, stall_cnt_o} !== {4'd15, 16'd15}) begin numMismatched++; $display("[TB] FAIL sat_reach_max: got small %0d wide %0d expected 15 15", sStallCnt, stall_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      setId(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
      tick();
      setId(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
      tick();
    end
    numCompared++; if (sStallCnt !== 4'hF) begin numMismatched++; $display("[TB] FAIL sat_hold_max: got %h expected f", sStallCnt); end
    numCompared++; if (stall_cnt_o !== 16'd19) begin numMismatched++; $display("[TB] FAIL sat_wide_count: got %0d expected 19", stall_cnt_o); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    numCompared = 0;
    numMismatched = 0;
    test_reset();
    test_load_use_rs();
    test_load_use_rt();
    test_zero_reg();
    test_flush_beats_stall();
    test_hold();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer side of the EX/MEM/WB forwarding interface. Tracks in-flight destination registers through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the destination address and RegWrite signals that the forwarding comparator consumes.
- Detects load-use hazards that forwarding cannot cover and issues the stall, bubble and flush controls.
- Sits beside the pipeline registers; it does not move the datapath, only destination and control metadata.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- hold_i  in  1  global pipeline freeze, e.g. memory not ready.
- valid_ID_i  in  1  ID stage holds a real instruction.
- RS_addr_ID_i  in  REG_AW  rs of the instruction in ID.
- RT_addr_ID_i  in  REG_AW  rt of the instruction in ID.
- uses_rt_ID_i  in  1  the ID instruction reads rt; 0 for I-type ALU and lw.
- dest_ID_i  in  REG_AW  destination after the RegDst mux.
- RegWrite_ID_i  in  1  the ID instruction writes the register file.
- MemRead_ID_i  in  1  the ID instruction is a load.
- branch_taken_EX_i  in  1  branch resolved taken in EX.
- RS_addr_IDEX_o  out  REG_AW  registered rs for the forwarding compare.
- RT_addr_IDEX_o  out  REG_AW  registered rt for the forwarding compare.
- Mux_RegDst_EXMEM_o  out  REG_AW  EX/MEM destination.
- Mux_RegDst_MEMWB_o  out  REG_AW  MEM/WB destination.
- EXMEM_WB1_o  out  1  EX/MEM RegWrite, qualified by valid.
- MEMWB_WB1_o  out  1  MEM/WB RegWrite, qualified by valid.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register enable.
- IFID_Flush_o  out  1  clear IF/ID.
- IDEX_Bubble_o  out  1  zero the ID/EX control fields.
- stall_cnt_o  out  CNT_W  saturating count of load-use stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Three tracker slots: IDEX, EXMEM, MEMWB. Each slot holds {valid, dest, regwrite, memread}; the IDEX slot also holds rs and rt.
- Reset (rst_i=0, asynchronous):
  - All slots cleared: valid 0, fields 0.
  - Counters 0.
  - Outputs: addresses 0, WB1 outputs 0, PCWrite_o=1, IFID_Write_o=1, IFID_Flush_o=0, IDEX_Bubble_o=0.
- Load-use hazard (lu), combinational:
  - lu = valid_ID_i & IDEX.valid & IDEX.memread & IDEX.regwrite & (IDEX.dest != 0) & (IDEX.dest == RS_addr_ID_i | (uses_rt_ID_i & IDEX.dest == RT_addr_ID_i)).
- Priority, evaluated every cycle:
  - hold_i=1:
    - All slots and counters keep their values.
    - PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0.
    - The forwarding outputs keep presenting the frozen slots.
  - Else if branch_taken_EX_i=1 (flush beats stall):
    - IFID_Flush_o=1, IDEX_Bubble_o=1, PCWrite_o=1, IFID_Write_o=1.
    - Next IDEX slot is a bubble (valid 0). EXMEM takes the old IDEX, MEMWB takes the old EXMEM.
    - flush_cnt +1.
  - Else if lu:
    - PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
    - Next IDEX is a bubble; the older slots shift normally.
    - stall_cnt +1.
  - Else: normal shift. IDEX loads the ID inputs, with valid = valid_ID_i.
- Stall length: exactly one cycle per load-use. On the next cycle the load sits in EXMEM, lu is false, and forwarding covers the MEM/WB distance.
- Forwarding outputs are registered: dest straight from the slot, WB1 = valid & regwrite. Outputs change only on a clock edge.
- Register 0:
  - A dest of 0 never causes lu.
  - WB1 may still be 1 with dest 0; the consumer masks register 0.
- Counters saturate at all-ones; they do not wrap.
- Reset in mid-stall or mid-flush: all state clears at once, with no residual stall on the next cycle.

Decomposition:
- Shared package holds:
  - REG_AW and the zero-register constant.
  - The tracker slot struct {valid, dest, regwrite, memread}.
  - Encodings of the forwarding select values (00 register file, 10 EX/MEM, 01 MEM/WB) so producer and consumer share them.
- One sub-module, sat_counter (width-parameterised, enable input, saturating), instantiated twice.

Test Plan:
- Load-use, rs: lw $2 in IDEX, then add $3,$2,$4 in ID.
  - Expect PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 for exactly 1 cycle; stall_cnt_o=1.
  - Next cycle Mux_RegDst_EXMEM_o=2 with EXMEM_WB1_o=1.
  - The cycle after that Mux_RegDst_MEMWB_o=2 with MEMWB_WB1_o=1.
- Load-use, rt only:
  - lw $5, then sw $5 with uses_rt=1 → stall.
  - Same lw, then addi $6,$7,1 with uses_rt=0 and RT=5 → no stall.
- Zero register: lw $0, then add $1,$0,$0 → no stall; stall_cnt_o stays 0.
- Flush beats stall: lu condition and branch_taken_EX_i=1 in the same cycle.
  - Expect IFID_Flush_o=1, PCWrite_o=1; flush_cnt_o=1, stall_cnt_o=0.
  - Next cycle EXMEM_WB1_o reflects the old IDEX contents.
- Hold: hold_i=1 for 3 cycles with the slots loaded.
  - Expect all destination and WB1 outputs unchanged, PCWrite_o=0, counters unchanged.
  - Release → shifting resumes.
- Reset mid-stall: assert rst_i=0 between clock edges during a stall.
  - Outputs reset immediately: PCWrite_o=1, WB1 outputs 0, counters 0.
- Saturation: force 2^CNT_W+3 stall cycles → stall_cnt_o holds at 16'hFFFF.
